// File: rtl/serial_subtractor_pkg.sv
// Shared state encodings, width defaults and helper functions for the
// bit-serial subtractor and its one-bit full-subtractor cell.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int SUB_W_DEFAULT = 8;

  typedef struct packed {
    logic d;
    logic b;
  } hs_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((32'sd1 <<< result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Half-subtractor cell: x - y with no borrow-in.
  function automatic hs_t hs(input logic x, input logic y);
    hs_t r;
    r.d = x ^ y;
    r.b = ~x & y;
    return r;
  endfunction

endpackage

// File: rtl/fs_bit.sv
// Combinational one-bit full subtractor (x - y - bin) built from two
// half-subtractor cells; the two partial borrows can never both be set.
module fs_bit
  import serial_subtractor_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  hs_t hs1_s;
  hs_t hs2_s;

  assign hs1_s = hs(x, y);
  assign hs2_s = hs(hs1_s.d, bin);
  assign d     = hs2_s.d;
  assign bout  = hs1_s.b | hs2_s.b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: a - b processed LSB first, one bit per clock,
// with a start/busy/done handshake and results held until the next completion.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int W = SUB_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         borrow
);

  localparam int CW = (clog2(W + 1) > 1) ? clog2(W + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e        state_q, state_d;
  logic [W-1:0]  sa_q, sa_d;
  logic [W-1:0]  sb_q, sb_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          br_q, br_d;
  logic          borrow_q, borrow_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          d_s;
  logic          bo_s;
  logic [W-1:0]  acc_shift_s;

  fs_bit u_fs_bit (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .bin  (br_q),
    .d    (d_s),
    .bout (bo_s)
  );

  // New difference bits enter at the MSB so the LSB-first stream lands in place.
  generate
    if (W == 1) begin : g_acc_w1
      assign acc_shift_s = d_s;
    end else begin : g_acc_wn
      assign acc_shift_s = {d_s, acc_q[W-1:1]};
    end
  endgenerate

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    acc_d    = acc_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    borrow_d = borrow_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          sa_d    = a;
          sb_d    = b;
          br_d    = 1'b0;
          cnt_d   = {CW{1'b0}};
          acc_d   = {W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sa_d  = sa_q >> 1'b1;
        sb_d  = sb_q >> 1'b1;
        acc_d = acc_shift_s;
        br_d  = bo_s;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d  = ST_DONE;
          diff_d   = acc_shift_s;
          borrow_d = bo_s;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sa_q     <= {W{1'b0}};
      sb_q     <= {W{1'b0}};
      acc_q    <= {W{1'b0}};
      diff_q   <= {W{1'b0}};
      cnt_q    <= {CW{1'b0}};
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      acc_q    <= acc_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: W=8 and W=1 instances, directed
// timing checks plus a scoreboard of expected results popped at each done.
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] diff;
    logic       borrow;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       borrow8;
  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       busy1;
  logic       done1;
  logic [0:0] diff1;
  logic       borrow1;

  exp_t exp_q[$];
  int   n_checks;
  int   n_pass;

  serial_subtractor #(.W(8)) dut8 (
    .clk    (clk),
    .rst    (rst),
    .start  (start8),
    .a      (a8),
    .b      (b8),
    .busy   (busy8),
    .done   (done8),
    .diff   (diff8),
    .borrow (borrow8)
  );

  serial_subtractor #(.W(1)) dut1 (
    .clk    (clk),
    .rst    (rst),
    .start  (start1),
    .a      (a1),
    .b      (b1),
    .busy   (busy1),
    .done   (done1),
    .diff   (diff1),
    .borrow (borrow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard: every done pulse of the W=8 instance must match the oldest expectation.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      chk("done_expected", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_diff", 32'(diff8), 32'(e.diff));
        chk("sb_borrow", 32'(borrow8), 32'(e.borrow));
      end
    end
  end

  // Drive one start pulse at a negedge; returns just after the accept edge.
  task automatic start8_op(input logic [7:0] av, input logic [7:0] bv);
    exp_t e;
    e.diff   = av - bv;
    e.borrow = (av < bv);
    exp_q.push_back(e);
    a8     = av;
    b8     = bv;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_done8(input int max_cycles);
    int n;
    n = 0;
    while (done8 !== 1'b1 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 32'(done8), 32'(1));
  endtask

  // Full operation with per-cycle busy/done timing checks and mid-RUN operand changes.
  task automatic timed_op8(input logic [7:0] av, input logic [7:0] bv);
    start8_op(av, bv);
    for (int i = 0; i < 8; i++) begin
      chk("busy_run", 32'(busy8), 32'(1));
      chk("done_run", 32'(done8), 32'(0));
      a8 = ~av;
      b8 = bv ^ 8'h5A;
      @(negedge clk);
    end
    chk("done_pulse", 32'(done8), 32'(1));
    chk("busy_in_done", 32'(busy8), 32'(0));
    @(negedge clk);
    chk("done_clear", 32'(done8), 32'(0));
    chk("busy_idle", 32'(busy8), 32'(0));
  endtask

  task automatic quick_op8(input logic [7:0] av, input logic [7:0] bv);
    start8_op(av, bv);
    a8 = $urandom_range(0, 255);
    b8 = $urandom_range(0, 255);
    wait_done8(12);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst    = 1'b1;
    start8 = 1'b0;
    a8     = 8'd0;
    b8     = 8'd0;
    start1 = 1'b0;
    a1     = 1'b0;
    b1     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy8), 32'(0));
    chk("rst_done", 32'(done8), 32'(0));
    chk("rst_diff", 32'(diff8), 32'(0));
    chk("rst_borrow", 32'(borrow8), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // Basic operation with exact latency.
    timed_op8(8'd100, 8'd58);
    chk("t1_diff", 32'(diff8), 32'h2A);
    chk("t1_borrow", 32'(borrow8), 32'(0));

    // Results hold through the next RUN until it completes.
    start8_op(8'd5, 8'd10);
    chk("hold_diff", 32'(diff8), 32'h2A);
    chk("hold_borrow", 32'(borrow8), 32'(0));
    wait_done8(12);
    @(negedge clk);
    chk("t2_diff", 32'(diff8), 32'hFB);
    timed_op8(8'd0, 8'd1);
    chk("wrap_diff", 32'(diff8), 32'hFF);
    chk("wrap_borrow", 32'(borrow8), 32'(1));
    timed_op8(8'hFF, 8'hFF);
    chk("eq_diff", 32'(diff8), 32'(0));

    // start held high: back-to-back operations every 10 cycles, mid-RUN a/b noise.
    a8 = 8'd3;
    b8 = 8'd1;
    start8 = 1'b1;
    for (int j = 0; j < 3; j++) begin
      exp_t e;
      e.diff   = 8'd2;
      e.borrow = 1'b0;
      exp_q.push_back(e);
    end
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk("b2b_done", 32'(done8), 32'((k % 10) == 8));
      chk("b2b_busy", 32'(busy8), 32'((k % 10) < 8));
      if ((k % 10) == 3) begin
        a8 = 8'd50;
        b8 = 8'd60;
      end
      if ((k % 10) == 6) begin
        a8 = 8'd3;
        b8 = 8'd1;
      end
      if (k == 29) start8 = 1'b0;
    end
    @(negedge clk);
    chk("b2b_idle", 32'(busy8), 32'(0));
    chk("b2b_drained", 32'(exp_q.size()), 32'(0));

    // Asynchronous reset in mid-RUN abandons the operation.
    timed_op8(8'd200, 8'd7);
    chk("pre_rst_diff", 32'(diff8), 32'd193);
    a8 = 8'd1;
    b8 = 8'd2;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy8), 32'(0));
    chk("arst_done", 32'(done8), 32'(0));
    chk("arst_diff", 32'(diff8), 32'(0));
    chk("arst_borrow", 32'(borrow8), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("no_done_after_rst", 32'(done8), 32'(0));
    end
    timed_op8(8'd9, 8'd4);
    chk("post_rst_diff", 32'(diff8), 32'd5);

    // W=1 instance: all four operand combinations.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] t;
      logic av;
      logic bv;
      av = (i >= 2);
      bv = ((i % 2) == 1);
      t  = {1'b0, av} - {1'b0, bv};
      a1 = av;
      b1 = bv;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("w1_busy", 32'(busy1), 32'(1));
      chk("w1_done_early", 32'(done1), 32'(0));
      @(negedge clk);
      chk("w1_done", 32'(done1), 32'(1));
      chk("w1_diff", 32'(diff1), 32'(t[0]));
      chk("w1_borrow", 32'(borrow1), 32'(t[1]));
      @(negedge clk);
      chk("w1_done_clear", 32'(done1), 32'(0));
    end

    // Randomized sweep against the arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      quick_op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    chk("sb_empty", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
